// File: rtl/alu_result_stage.sv
// ALU result register stage: valid/ready buffered result R plus Z/C flags with an interrupt shadow copy.
// Define ALU_RESULT_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready; default is 1-entry.
module alu_result_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] SUM,
  input  logic       cadd,
  input  logic [1:0] S,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flag_we,
  output logic [7:0] R,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       Z,
  output logic       C,
  output logic       cin,
  input  logic       int_save,
  input  logic       int_restore
);

  logic       accept;
  logic       transfer;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [1:0] shadow_q, shadow_d;
  logic       unused_sel;

  // Subtract ops reach the adder with an inverted carry encoding; flip it back to a borrow flag.
  function automatic logic recover_carry(input logic sub_op, input logic carry_raw);
    return sub_op ? ~carry_raw : carry_raw;
  endfunction

  assign accept     = in_valid && in_ready;
  assign transfer   = out_valid && out_ready;
  assign unused_sel = S[0];

  assign Z   = z_q;
  assign C   = c_q;
  assign cin = c_q;

  always_comb begin
    z_d      = z_q;
    c_d      = c_q;
    shadow_d = shadow_q;
    if (accept && flag_we) begin
      z_d = (SUM == 8'h00);
      c_d = recover_carry(S[1], cadd);
    end
    if (int_restore) begin
      {z_d, c_d} = shadow_q;
    end
    if (int_save) begin
      shadow_d = {z_q, c_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      shadow_q <= 2'b00;
    end else begin
      z_q      <= z_d;
      c_q      <= c_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef ALU_RESULT_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e     state_q, state_d;
  logic [7:0] head_q, head_d;
  logic [7:0] tail_q, tail_d;
  logic       rdy_q, rdy_d;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign R         = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = SUM;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({accept, transfer})
          2'b10: begin
            tail_d  = SUM;
            state_d = TWO;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = SUM;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen; tail moves up to head.
        if (transfer) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= 8'h00;
      tail_q  <= 8'h00;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= rdy_d;
    end
  end
`else
  typedef enum logic {EMPTY, FULL} state_e;

  state_e     state_q, state_d;
  logic [7:0] r_q, r_d;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign R         = r_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    if (accept) begin
      r_d = SUM;
    end
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (transfer && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      r_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end
`endif

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset is asynchronous and active-low.
REQ-003 SUM  input  8  raw sum from the 8-bit adder fed by the operand extender.
REQ-004 cadd  input  1  raw adder carry out.
REQ-005 S  input  2  operation select: 00 add, 01 addc, 10 sub, 11 subc.
REQ-006 in_valid  input  1  SUM/cadd/S/flag_we are valid this cycle.
REQ-007 in_ready  output  1  stage can accept a result this cycle.
REQ-008 flag_we  input  1  accepted result updates Z/C flags.
REQ-009 R  output  8  registered result.
REQ-010 out_valid  output  1  R holds an unconsumed result.
REQ-011 out_ready  input  1  consumer takes R this cycle.
REQ-012 Z  output  1  zero flag register.
REQ-013 C  output  1  carry flag register; the architectural carry, 1 = carry on add, 1 = borrow on sub.
REQ-014 cin  output  1  carry to operand extender; SHALL equal C combinationally.
REQ-015 int_save  input  1  one-cycle pulse: copy Z,C into shadow flags.
REQ-016 int_restore  input  1  one-cycle pulse: copy shadow flags into Z,C.

Function
REQ-017 Accept = in_valid && in_ready; transfer = out_valid && out_ready.
REQ-018 On accept, the stage SHALL capture SUM into R with R visible the next cycle (latency 1).
REQ-019 Carry recovery: S[1]=0 -> new C = cadd; S[1]=1 -> new C = ~cadd (undoes the operand extender's inverted carry encoding).
REQ-020 New Z = (SUM == 8'h00), computed on the full 8 bits.
REQ-021 Z and C SHALL update on accept only when flag_we=1, in the same edge that loads R; otherwise they hold.
REQ-022 State machine EMPTY/FULL (1-entry build): EMPTY->FULL on accept; FULL->EMPTY on transfer without accept; FULL->FULL on simultaneous transfer and accept (R replaced).
REQ-023 1-entry build: in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
REQ-024 out_valid SHALL be 1 exactly in FULL (or any non-empty skid state).
REQ-025 R SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 int_save: shadow <= {Z,C} at the edge, using flag values before any same-cycle update.
REQ-027 int_restore: {Z,C} <= shadow; takes priority over a same-cycle flag_we update, whose result still loads R.
REQ-028 int_save and int_restore asserted together: restore applies to Z,C and save captures the pre-edge Z,C (swap).
REQ-029 Handshake state, R, and flags are independent: int_* pulses SHALL NOT change out_valid or R.

Reset
REQ-030 While rst_n=0: R=8'h00, out_valid=0, Z=0, C=0, cin=0, shadow=2'b00, state EMPTY, in_ready=1 (1-entry) / 0 (skid build until first clk after release).
REQ-031 Reset mid-operation SHALL discard any buffered result; no transfer is reported after release.

Configuration
REQ-032 Macro ALU_RESULT_STAGE_SKID_EN defined: a 2-entry buffer (states EMPTY/ONE/TWO) with in_ready registered, = 1 iff fewer than 2 entries held; order preserved, flags still update at accept time.
REQ-033 Macro ALU_RESULT_STAGE_SKID_EN undefined: 1-entry behaviour of REQ-022/023, no combinational path other than out_ready->in_ready and C->cin.

Verification
REQ-034 S=00, SUM=8'h00, cadd=1, flag_we=1, accept -> next cycle R=00, Z=1, C=1, cin=1, out_valid=1.
REQ-035 S=10, SUM=8'h05, cadd=1, flag_we=1 -> R=05, Z=0, C=0 (no borrow); repeat with cadd=0 -> C=1.
REQ-036 out_ready=0 with FULL, new in_valid -> in_ready=0 (1-entry), R held; skid build accepts exactly one more, then in_ready=0; drain order matches input.
REQ-037 Z=1,C=1, int_save; then op sets Z=0,C=0; then int_restore with same-cycle flag_we op -> Z=1,C=1, R = new SUM.
REQ-038 rst_n low while FULL with R=8'hA5 -> immediately out_valid=0, R=00, Z=C=0; after release no stale transfer.
